// File: rtl/sdf_fft_pkg.sv
// sdf_fft_pkg: shared widths and Q.10 twiddle tables for the 128-point SDF FFT first stage
package sdf_fft_pkg;
  localparam int DATA_W = 22;
  localparam int OUT_W  = 32;
  localparam int FRAC_W = 10;
  localparam int DEPTH  = 64;
  localparam int PHI_W  = 6;
  localparam int COEF_W = FRAC_W + 2;
  localparam logic signed [COEF_W-1:0] COS_TAB [DEPTH] = '{
    12'sd1024, 12'sd1019, 12'sd1004, 12'sd980, 12'sd946, 12'sd903, 12'sd851, 12'sd792,
    12'sd724, 12'sd650, 12'sd569, 12'sd483, 12'sd392, 12'sd297, 12'sd200, 12'sd100,
    12'sd0, -12'sd100, -12'sd200, -12'sd297, -12'sd392, -12'sd483, -12'sd569, -12'sd650,
    -12'sd724, -12'sd792, -12'sd851, -12'sd903, -12'sd946, -12'sd980, -12'sd1004, -12'sd1019,
    -12'sd1024, -12'sd1019, -12'sd1004, -12'sd980, -12'sd946, -12'sd903, -12'sd851, -12'sd792,
    -12'sd724, -12'sd650, -12'sd569, -12'sd483, -12'sd392, -12'sd297, -12'sd200, -12'sd100,
    12'sd0, 12'sd100, 12'sd200, 12'sd297, 12'sd392, 12'sd483, 12'sd569, 12'sd650,
    12'sd724, 12'sd792, 12'sd851, 12'sd903, 12'sd946, 12'sd980, 12'sd1004, 12'sd1019
  };
  localparam logic signed [COEF_W-1:0] SIN_TAB [DEPTH] = '{
    12'sd0, 12'sd100, 12'sd200, 12'sd297, 12'sd392, 12'sd483, 12'sd569, 12'sd650,
    12'sd724, 12'sd792, 12'sd851, 12'sd903, 12'sd946, 12'sd980, 12'sd1004, 12'sd1019,
    12'sd1024, 12'sd1019, 12'sd1004, 12'sd980, 12'sd946, 12'sd903, 12'sd851, 12'sd792,
    12'sd724, 12'sd650, 12'sd569, 12'sd483, 12'sd392, 12'sd297, 12'sd200, 12'sd100,
    12'sd0, -12'sd100, -12'sd200, -12'sd297, -12'sd392, -12'sd483, -12'sd569, -12'sd650,
    -12'sd724, -12'sd792, -12'sd851, -12'sd903, -12'sd946, -12'sd980, -12'sd1004, -12'sd1019,
    -12'sd1024, -12'sd1019, -12'sd1004, -12'sd980, -12'sd946, -12'sd903, -12'sd851, -12'sd792,
    -12'sd724, -12'sd650, -12'sd569, -12'sd483, -12'sd392, -12'sd297, -12'sd200, -12'sd100
  };
endpackage

// File: rtl/twiddle_rotator.sv
// twiddle_rotator: combinational multiply of a real sample by W64^k, full-precision Q.10 result
module twiddle_rotator
  import sdf_fft_pkg::*;
(
  input  logic signed [DATA_W-1:0] iData,
  input  logic        [PHI_W-1:0]  iPhi,
  output logic signed [OUT_W-1:0]  oReal,
  output logic signed [OUT_W-1:0]  oImage
);
  logic signed [COEF_W-1:0] w_cos;
  logic signed [COEF_W-1:0] w_sin;
  assign w_cos  = COS_TAB[iPhi];
  assign w_sin  = SIN_TAB[iPhi];
  // W^k = cos - j*sin, so the imaginary product is negated
  assign oReal  = OUT_W'(iData) * OUT_W'(w_cos);
  assign oImage = -(OUT_W'(iData) * OUT_W'(w_sin));
endmodule

// File: rtl/sdf_delay_rotator.sv
// sdf_delay_rotator: enable-gated 64-deep delay line feeding a W64^k twiddle rotator
module sdf_delay_rotator
  import sdf_fft_pkg::*;
(
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic                     iEn,
  input  logic signed [DATA_W-1:0] iData,
  input  logic        [PHI_W-1:0]  iPhi,
  output logic signed [DATA_W-1:0] oData,
  output logic signed [OUT_W-1:0]  oReal,
  output logic signed [OUT_W-1:0]  oImage
);
  logic signed [DATA_W-1:0] r_mem [DEPTH];
  logic        [PHI_W-1:0]  r_ptr;
  // circular buffer: the slot about to be overwritten holds the oldest sample
  always_ff @(posedge iClk) begin
    if (iRst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_ptr <= '0;
    end else if (iEn) begin
      r_mem[r_ptr] <= iData;
      r_ptr        <= r_ptr + 1'b1;
    end
  end
  assign oData = r_mem[r_ptr];
  twiddle_rotator u_rot (
    .iData (oData),
    .iPhi  (iPhi),
    .oReal (oReal),
    .oImage(oImage)
  );
endmodule

// File: tb/tb_sdf_delay_rotator.sv
// tb_sdf_delay_rotator: randomized and directed checks against a queue + trig reference model
module tb_sdf_delay_rotator;
  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               en = 1'b0;
  logic signed [21:0] data = '0;
  logic        [5:0]  phi = '0;
  logic signed [21:0] o_data;
  logic signed [31:0] o_real;
  logic signed [31:0] o_image;
  int                 n_pass = 0;
  int                 n_total = 0;
  logic signed [21:0] q [$];
  logic signed [21:0] held;
  sdf_delay_rotator dut (
    .iClk  (clk),
    .iRst  (rst),
    .iEn   (en),
    .iData (data),
    .iPhi  (phi),
    .oData (o_data),
    .oReal (o_real),
    .oImage(o_image)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag, $signed(got), got, $signed(exp), exp);
    else n_pass++;
  endtask
  function automatic int rnd(input real v);
    return v >= 0.0 ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
  endfunction
  function automatic logic [31:0] exp_re(input int d, input int k);
    longint p = longint'(d) * rnd(1024.0 * $cos(2.0 * 3.14159265358979 * k / 64.0));
    return p[31:0];
  endfunction
  function automatic logic [31:0] exp_im(input int d, input int k);
    longint p = -(longint'(d) * rnd(1024.0 * $sin(2.0 * 3.14159265358979 * k / 64.0)));
    return p[31:0];
  endfunction
  task automatic model_clear();
    q = {};
    for (int i = 0; i < 64; i++) q.push_back('0);
  endtask
  task automatic cyc(input logic e, input logic signed [21:0] d, input logic [5:0] p, input logic r);
    @(negedge clk);
    en = e; data = d; phi = p; rst = r;
    #1;
    check("odata", 32'(o_data), 32'(q[0]));
    check("oreal", o_real, exp_re(int'(q[0]), int'(p)));
    check("oimag", o_image, exp_im(int'(q[0]), int'(p)));
    @(posedge clk);
    if (r) model_clear();
    else if (e) begin
      q.push_back(d);
      void'(q.pop_front());
    end
  endtask
  task automatic load_one(input logic signed [21:0] s);
    cyc(1'b0, '0, '0, 1'b1);
    cyc(1'b1, s, '0, 1'b0);
    for (int i = 0; i < 63; i++) cyc(1'b1, '0, '0, 1'b0);
  endtask
  initial begin
    model_clear();
    cyc(1'b1, 22'sd5, '0, 1'b1);
    #1 check("rst_odata", 32'(o_data), 32'd0);
    check("rst_oreal", o_real, 32'd0);
    for (int i = 1; i <= 64; i++) cyc(1'b1, 22'(i), '0, 1'b0);
    #1 check("t1_odata", 32'(o_data), 32'd1);
    check("t1_oreal", o_real, 32'd1024);
    check("t1_oimag", o_image, 32'd0);
    held = o_data;
    for (int i = 0; i < 20; i++) cyc(1'b0, 22'(i + 500), 6'(i), 1'b0);
    #1 check("t2_hold", 32'(o_data), 32'(held));
    for (int i = 65; i <= 70; i++) cyc(1'b1, 22'(i), '0, 1'b0);
    #1 check("t2_resume", 32'(o_data), 32'd7);
    load_one(22'sd100);
    cyc(1'b0, '0, 6'd0, 1'b0);
    #1 check("k0_re", o_real, 32'd102400);
    check("k0_im", o_image, 32'd0);
    cyc(1'b0, '0, 6'd8, 1'b0);
    #1 check("k8_re", o_real, 32'd72400);
    check("k8_im", o_image, -32'sd72400);
    cyc(1'b0, '0, 6'd16, 1'b0);
    #1 check("k16_re", o_real, 32'd0);
    check("k16_im", o_image, -32'sd102400);
    cyc(1'b0, '0, 6'd32, 1'b0);
    #1 check("k32_re", o_real, -32'sd102400);
    check("k32_im", o_image, 32'd0);
    cyc(1'b0, '0, 6'd48, 1'b0);
    #1 check("k48_re", o_real, 32'd0);
    check("k48_im", o_image, 32'd102400);
    load_one(-22'sd2097151);
    cyc(1'b0, '0, 6'd16, 1'b0);
    #1 check("ext_im", o_image, 32'd2147482624);
    check("ext_re", o_real, 32'd0);
    for (int i = 0; i < 30; i++) cyc(1'b1, 22'sd7, 6'(i), 1'b0);
    cyc(1'b1, 22'sd9, '0, 1'b1);
    #1 check("t5_odata", 32'(o_data), 32'd0);
    for (int i = 0; i < 64; i++) cyc(1'b1, 22'(i + 1), 6'(i), 1'b0);
    #1 check("t5_first", 32'(o_data), 32'd1);
    for (int i = 0; i < 10000; i++)
      cyc($urandom_range(3, 0) != 0, 22'($urandom), 6'($urandom), $urandom_range(499, 0) == 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
